// File: rtl/sata_oob_detector.sv
// sata_oob_detector
//
// Receive-side Serial ATA out-of-band detector. Synchronizes the PHY squelch,
// measures every burst and gap in clk cycles, classifies each gap as a
// COMWAKE-type or COMINIT/COMRESET-type gap, and pulses cominit or comwake for
// one cycle once GAPS consecutive gaps of the same type have been seen.
//
// Parameters
//   CLKFREQ    clk frequency in kHz
//   GAPS       consecutive same-type valid gaps needed for a detection (2..7)
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   en         detector enable; low holds the detector in QUIET with no pulses
//   rxelecidle PHY squelch (1 = idle, 0 = burst), asynchronous to clk
//   cominit    one-cycle pulse, COMINIT/COMRESET sequence detected
//   comwake    one-cycle pulse, COMWAKE sequence detected
//   rxidle     rxelecidle after the two-flop synchronizer
module sata_oob_detector #(
  parameter int CLKFREQ = 100_000,
  parameter int GAPS    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic rxelecidle,
  output logic cominit,
  output logic comwake,
  output logic rxidle
);

  // Nanoseconds to clk cycles, rounded to nearest.
  function automatic int ns_to_cyc(input int ns);
    longint prod;
    prod = longint'(ns) * longint'(CLKFREQ) + 64'sd500_000;
    return int'(prod / 64'sd1_000_000);
  endfunction

  localparam int T35   = ns_to_cyc(35);
  localparam int T175  = ns_to_cyc(175);
  localparam int T525  = ns_to_cyc(525);
  localparam int CNT_W = $clog2(T525 + 1);
  localparam int SEQ_W = $clog2(GAPS + 1);

  localparam logic [CNT_W-1:0] T35_C   = CNT_W'(T35);
  localparam logic [CNT_W-1:0] T175_C  = CNT_W'(T175);
  localparam logic [CNT_W-1:0] T525_C  = CNT_W'(T525);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] GAPS_C  = SEQ_W'(GAPS);

  typedef enum logic [1:0] {QUIET, BURST, GAP, BLOCK} state_t;
  typedef enum logic [1:0] {GAP_BAD, GAP_WAKE, GAP_INIT} gap_t;

  function automatic gap_t classify(input logic [CNT_W-1:0] g);
    if (g > T35_C && g < T175_C)   return GAP_WAKE;
    if (g >= T175_C && g < T525_C) return GAP_INIT;
    return GAP_BAD;
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [SEQ_W-1:0] seq, seq_nx, seq_inc;
  logic             tp, tp_nx;
  logic             init_nx, wake_nx;
  gap_t             gap_kind;
  logic             gap_init;

  // Stage p0/p1: two-flop squelch synchronizer; sync_p1 is idle_s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rxelecidle;
      sync_p1 <= sync_p0;
    end
  end

  assign rxidle   = sync_p1;
  assign cnt_inc  = cnt + CNT_ONE;
  assign seq_inc  = seq + SEQ_ONE;
  // cnt holds the gap length at the cycle the gap ends.
  assign gap_kind = classify(cnt);
  assign gap_init = (gap_kind == GAP_INIT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seq_nx   = seq;
    tp_nx    = tp;
    init_nx  = 1'b0;
    wake_nx  = 1'b0;
    case (state)
      QUIET: begin
        if (!sync_p1) begin
          state_nx = BURST;
          cnt_nx   = CNT_ONE;
        end
      end
      BURST: begin
        if (!sync_p1) begin
          cnt_nx = cnt_inc;
          // Burst too long to be OOB signalling: treat as a live line.
          if (cnt_inc == T525_C) begin
            state_nx = BLOCK;
            seq_nx   = '0;
          end
        end else if (cnt <= T35_C) begin
          state_nx = QUIET;
          seq_nx   = '0;
        end else begin
          state_nx = GAP;
          cnt_nx   = CNT_ONE;
        end
      end
      GAP: begin
        if (sync_p1) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == T525_C) begin
            state_nx = QUIET;
            seq_nx   = '0;
          end
        end else begin
          state_nx = BURST;
          cnt_nx   = CNT_ONE;
          if (gap_kind == GAP_BAD) begin
            seq_nx = '0;
          end else if (seq == '0 || tp != gap_init) begin
            // First gap of a run, or the type changed: restart the run.
            tp_nx  = gap_init;
            seq_nx = SEQ_ONE;
          end else if (seq_inc == GAPS_C) begin
            seq_nx  = '0;
            init_nx = gap_init;
            wake_nx = !gap_init;
          end else begin
            seq_nx = seq_inc;
          end
        end
      end
      BLOCK: begin
        if (sync_p1) state_nx = QUIET;
      end
      default: state_nx = QUIET;
    endcase
  end

  // Stage p2: detector state and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= QUIET;
      cnt     <= '0;
      seq     <= '0;
      tp      <= 1'b0;
      cominit <= 1'b0;
      comwake <= 1'b0;
    end else if (!en) begin
      state   <= QUIET;
      cnt     <= '0;
      seq     <= '0;
      tp      <= 1'b0;
      cominit <= 1'b0;
      comwake <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      seq     <= seq_nx;
      tp      <= tp_nx;
      cominit <= init_nx;
      comwake <= wake_nx;
    end
  end

endmodule

// File: tb/tb_sata_oob_detector.sv
// tb_sata_oob_detector
//
// Directed bench for sata_oob_detector at CLKFREQ=100_000, GAPS=3
// (T35=4, T175=18, T525=53). Burst/gap trains come from a table; reset,
// enable and synchronizer latency are exercised by hand-written sequences.
module tb_sata_oob_detector;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic rxelecidle;
  logic cominit;
  logic comwake;
  logic rxidle;

  sata_oob_detector #(.CLKFREQ(100_000), .GAPS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rxelecidle (rxelecidle),
    .cominit    (cominit),
    .comwake    (comwake),
    .rxidle     (rxidle)
  );

  always #5 clk = ~clk;

  int   total   = 0;
  int   bad     = 0;
  int   ncyc    = 0;
  int   n_init  = 0;
  int   n_wake  = 0;
  int   init_at = -1;
  int   wake_at = -1;
  int   both_hi = 0;
  int   trk_err = 0;
  bit   trk     = 1'b0;
  logic prev_lvl = 1'b1;

  typedef struct {
    string nm;
    int    nb;      // number of bursts (gaps = nb-1)
    int    sp_idx;  // burst index with non-default length, -1 none
    int    sp_len;
    int    g[6];    // gap after burst i
    int    e_init;
    int    e_wake;
    int    e_at;    // burst index whose start completes the run, -1 none
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input int nb, input int sp_idx,
                              input int sp_len, input int g0, input int g1,
                              input int g2, input int g3, input int g4,
                              input int g5, input int e_init, input int e_wake,
                              input int e_at);
    vec_t v;
    v.nm = nm; v.nb = nb; v.sp_idx = sp_idx; v.sp_len = sp_len;
    v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3; v.g[4] = g4; v.g[5] = g5;
    v.e_init = e_init; v.e_wake = e_wake; v.e_at = e_at;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one line level for one clk cycle, then sample just after the edge.
  task automatic step(input logic lvl);
    rxelecidle = lvl;
    @(posedge clk);
    #1;
    ncyc++;
    if (cominit) begin n_init++; init_at = ncyc; end
    if (comwake) begin n_wake++; wake_at = ncyc; end
    if (cominit && comwake) both_hi++;
    if (trk && rxidle !== prev_lvl) trk_err++;
    prev_lvl = lvl;
  endtask

  task automatic run_n(input logic lvl, input int n);
    for (int k = 0; k < n; k++) step(lvl);
  endtask

  task automatic clr();
    n_init = 0; n_wake = 0; init_at = -1; wake_at = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs[8];
    int blen;

    tbl.push_back(mk("cominit",  6, -1,  0, 32, 32, 32, 32, 32,  0, 1, 0, 3));
    tbl.push_back(mk("comwake",  6, -1,  0, 11, 11, 11, 11, 11,  0, 0, 1, 3));
    tbl.push_back(mk("gap4_bad", 6, -1,  0, 11, 11,  4, 11, 11,  0, 0, 0, -1));
    tbl.push_back(mk("gap5",     4, -1,  0,  5,  5,  5,  0,  0,  0, 0, 1, 3));
    tbl.push_back(mk("gap17",    4, -1,  0, 17, 17, 17,  0,  0,  0, 0, 1, 3));
    tbl.push_back(mk("gap18",    4, -1,  0, 18, 18, 18,  0,  0,  0, 1, 0, 3));
    tbl.push_back(mk("gap52",    4, -1,  0, 52, 52, 52,  0,  0,  0, 1, 0, 3));
    tbl.push_back(mk("gap53_to", 6, -1,  0, 32, 32, 53, 32, 32,  0, 0, 0, -1));
    tbl.push_back(mk("mixed",    6, -1,  0, 11, 11, 32, 32, 32,  0, 1, 0, 5));
    tbl.push_back(mk("noise",    7,  2,  4, 32, 32, 32, 32, 32, 32, 1, 0, 6));
    tbl.push_back(mk("block",    7,  2, 60, 32, 32, 32, 32, 32, 32, 1, 0, 6));

    // Reset state, with the line active during reset.
    reset = 1'b1; en = 1'b1; rxelecidle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rxidle", rxidle, 1);
    chk("reset cominit", cominit, 0);
    chk("reset comwake", comwake, 0);
    rxelecidle = 1'b1;
    reset = 1'b0;
    run_n(1'b1, 5);

    // rxidle lags rxelecidle by two edges.
    step(1'b0);
    chk("rxidle lag edge1", rxidle, 1);
    step(1'b0);
    chk("rxidle lag edge2", rxidle, 0);
    step(1'b0);
    step(1'b1);
    chk("rxidle lag rise", rxidle, 0);
    run_n(1'b1, 10);
    chk("rxidle idle", rxidle, 1);

    // Table-driven burst/gap trains, each ending in a timeout to QUIET.
    foreach (tbl[i]) begin
      clr();
      for (int b = 0; b < tbl[i].nb; b++) begin
        blen = (b == tbl[i].sp_idx) ? tbl[i].sp_len : 11;
        bs[b] = ncyc + 1;
        run_n(1'b0, blen);
        if (b < tbl[i].nb - 1) run_n(1'b1, tbl[i].g[b]);
      end
      run_n(1'b1, 60);
      chk($sformatf("%s cominit count", tbl[i].nm), n_init, tbl[i].e_init);
      chk($sformatf("%s comwake count", tbl[i].nm), n_wake, tbl[i].e_wake);
      if (tbl[i].e_at >= 0) begin
        chk($sformatf("%s pulse cycle", tbl[i].nm),
            (tbl[i].e_init != 0) ? init_at : wake_at, bs[tbl[i].e_at] + 2);
      end
      chk($sformatf("%s rxidle end", tbl[i].nm), rxidle, 1);
    end

    // Reset in the middle of an init run: pre-reset gaps are forgotten.
    clr();
    run_n(1'b0, 11); run_n(1'b1, 32);
    run_n(1'b0, 11); run_n(1'b1, 32);
    run_n(1'b0, 5);
    reset = 1'b1;
    #1;
    chk("midreset rxidle", rxidle, 1);
    chk("midreset cominit", cominit, 0);
    step(1'b0);
    reset = 1'b0;
    run_n(1'b0, 6); run_n(1'b1, 32);
    run_n(1'b0, 11); run_n(1'b1, 60);
    chk("midreset no pulse", n_init + n_wake, 0);

    // Disabled during a full COMWAKE train: no pulse, rxidle still tracks.
    clr();
    en = 1'b0;
    trk = 1'b1;
    for (int b = 0; b < 6; b++) begin
      run_n(1'b0, 11);
      if (b < 5) run_n(1'b1, 11);
    end
    run_n(1'b1, 5);
    trk = 1'b0;
    run_n(1'b1, 55);
    chk("disabled pulses", n_init + n_wake, 0);
    chk("disabled rxidle track", trk_err, 0);

    // Re-enabled: the same train is detected again.
    clr();
    en = 1'b1;
    step(1'b1);
    for (int b = 0; b < 6; b++) begin
      run_n(1'b0, 11);
      if (b < 5) run_n(1'b1, 11);
    end
    run_n(1'b1, 60);
    chk("reenabled comwake", n_wake, 1);
    chk("reenabled cominit", n_init, 0);

    chk("exclusive outputs", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
